// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared types and field layout for the led_ctrl LED driver.
//   - mode_e      : channel mode encoding (OFF, ON, PWM, BLINK, BREATHE)
//   - CFG_* / *_LSB / *_W : bit layout of cfg_wdata / cfg_rdata
//   - chan_cfg_t  : per-channel configuration {mode, level, period}
//   - cfg_unpack / cfg_pack : convert between the bus word and chan_cfg_t
package led_ctrl_pkg;

    typedef enum logic [2:0] {
        MODE_OFF     = 3'd0,
        MODE_ON      = 3'd1,
        MODE_PWM     = 3'd2,
        MODE_BLINK   = 3'd3,
        MODE_BREATHE = 3'd4
    } mode_e;

    localparam int CFG_W      = 24;
    localparam int MODE_LSB   = 0;
    localparam int MODE_W     = 3;
    localparam int LEVEL_LSB  = 8;
    localparam int LEVEL_W    = 8;
    localparam int PERIOD_LSB = 16;
    localparam int PERIOD_W   = 8;

    // mode is kept as raw bits so the reserved codes 5..7 survive readback
    typedef struct packed {
        logic [MODE_W-1:0]   mode;
        logic [LEVEL_W-1:0]  level;
        logic [PERIOD_W-1:0] period;
    } chan_cfg_t;

    function automatic chan_cfg_t cfg_unpack(input logic [CFG_W-1:0] word);
        chan_cfg_t c;
        c.mode   = word[MODE_LSB +: MODE_W];
        c.level  = word[LEVEL_LSB +: LEVEL_W];
        c.period = word[PERIOD_LSB +: PERIOD_W];
        return c;
    endfunction

    // Unused bus bits read back as 0.
    function automatic logic [CFG_W-1:0] cfg_pack(input chan_cfg_t c);
        logic [CFG_W-1:0] word;
        word = '0;
        word[MODE_LSB +: MODE_W]     = c.mode;
        word[LEVEL_LSB +: LEVEL_W]   = c.level;
        word[PERIOD_LSB +: PERIOD_W] = c.period;
        return word;
    endfunction

endpackage

// File: rtl/led_ctrl_chan.sv
// led_ctrl_chan: one LED channel. Holds its configuration, the blink /
// breathe state and produces the internal on/off value (raw).
// Optional breathe mode is compiled in with `define LED_CTRL_BREATHE_EN.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   we          : write strobe for this channel (address already decoded)
//   wcfg        : new configuration taken when we=1
//   frame_tick  : one-cycle pulse per PWM frame
//   pwm_cnt     : shared PWM counter
//   cfg         : current configuration (for readback)
//   raw         : internal LED state, 1 = lit
module led_ctrl_chan
    import led_ctrl_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  chan_cfg_t           wcfg,
    input  logic                frame_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output chan_cfg_t           cfg,
    output logic                raw
);

    chan_cfg_t           cfg_reg;
    logic [PERIOD_W-1:0] div_reg;    // frames counted since the last period hit
    logic                phase_reg;  // blink phase
    logic                div_hit;

    // Blink and breathe share one frame divider; they are never active together.
    assign div_hit = frame_tick && (div_reg == cfg_reg.period);

    // A write restarts all time-based state, even if a frame tick lands in
    // the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_reg   <= '0;
            div_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (we) begin
            cfg_reg   <= wcfg;
            div_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (frame_tick) begin
            if (div_hit) begin
                div_reg   <= '0;
                phase_reg <= ~phase_reg;
            end else begin
                div_reg <= div_reg + 1'b1;
            end
        end
    end

`ifdef LED_CTRL_BREATHE_EN
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    logic [PWM_BITS-1:0] duty_reg;
    logic                down_reg;

    // Triangle ramp 0..max..0; each endpoint is visited for exactly one step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_reg <= '0;
            down_reg <= 1'b0;
        end else if (we) begin
            duty_reg <= '0;
            down_reg <= 1'b0;
        end else if (div_hit) begin
            if (!down_reg) begin
                if (duty_reg == DUTY_MAX) begin
                    down_reg <= 1'b1;
                    duty_reg <= duty_reg - 1'b1;
                end else begin
                    duty_reg <= duty_reg + 1'b1;
                end
            end else begin
                if (duty_reg == '0) begin
                    down_reg <= 1'b0;
                    duty_reg <= duty_reg + 1'b1;
                end else begin
                    duty_reg <= duty_reg - 1'b1;
                end
            end
        end
    end
`endif

    always_comb begin
        raw = 1'b0;
        case (cfg_reg.mode)
            MODE_ON:      raw = 1'b1;
            MODE_PWM:     raw = (pwm_cnt < cfg_reg.level[PWM_BITS-1:0]);
            MODE_BLINK:   raw = phase_reg;
`ifdef LED_CTRL_BREATHE_EN
            MODE_BREATHE: raw = (pwm_cnt < duty_reg);
`endif
            default:      raw = 1'b0;
        endcase
    end

    assign cfg = cfg_reg;

endmodule

// File: rtl/led_ctrl.sv
// led_ctrl: multi-channel LED driver (off / on / PWM dim / blink, optional
// breathe when compiled with `define LED_CTRL_BREATHE_EN).
// Keeps the prescaler, PWM counter, address decode, readback and pin polarity;
// per-channel state lives in led_ctrl_chan.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   cfg_we      : write strobe (one cycle per write)
//   cfg_re      : read strobe
//   cfg_addr    : channel index; indices >= NUM_LEDS are ignored / read 0
//   cfg_wdata   : [2:0] mode, [15:8] level, [23:16] period
//   cfg_rdata   : registered readback, same layout, unused bits 0
//   frame_tick  : one-cycle pulse when the PWM counter wraps to 0
//   led         : physical LED pins, inverted when ACTIVE_LOW=1
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int NUM_LEDS   = 3,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE   = 520,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic                cfg_re,
    input  logic [3:0]          cfg_addr,
    input  logic [CFG_W-1:0]    cfg_wdata,
    output logic [CFG_W-1:0]    cfg_rdata,
    output logic                frame_tick,
    output logic [NUM_LEDS-1:0] led
);

    localparam int                  PRE_W    = $clog2(PRESCALE);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [NUM_LEDS-1:0] POL_MASK = {NUM_LEDS{ACTIVE_LOW != 0}};

    logic [PRE_W-1:0]    presc_reg;
    logic [PWM_BITS-1:0] pwm_reg;
    logic                frame_tick_reg;
    logic [CFG_W-1:0]    cfg_rdata_reg;
    logic [NUM_LEDS-1:0] led_reg;

    logic                step;
    chan_cfg_t           wcfg;
    chan_cfg_t           cfg_arr [NUM_LEDS];
    logic [NUM_LEDS-1:0] we_vec;
    logic [NUM_LEDS-1:0] raw_vec;
    logic [CFG_W-1:0]    rd_sel;

    assign step = (presc_reg == PRE_LAST);
    assign wcfg = cfg_unpack(cfg_wdata);

    // Out-of-range addresses match no channel, so writes to them have no effect.
    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
            assign we_vec[gi] = cfg_we && (cfg_addr == 4'(gi));

            led_ctrl_chan #(
                .PWM_BITS (PWM_BITS)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .we         (we_vec[gi]),
                .wcfg       (wcfg),
                .frame_tick (frame_tick_reg),
                .pwm_cnt    (pwm_reg),
                .cfg        (cfg_arr[gi]),
                .raw        (raw_vec[gi])
            );
        end
    endgenerate

    // Readback samples the current (pre-write) registers of the channel.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (cfg_addr == 4'(i)) begin
                rd_sel = cfg_pack(cfg_arr[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg      <= '0;
            pwm_reg        <= '0;
            frame_tick_reg <= 1'b0;
            cfg_rdata_reg  <= '0;
            led_reg        <= POL_MASK;
        end else begin
            presc_reg      <= step ? '0 : presc_reg + 1'b1;
            if (step) begin
                pwm_reg <= pwm_reg + 1'b1;
            end
            // High while pwm_reg sits at 0 right after the wrap.
            frame_tick_reg <= step && (pwm_reg == '1);
            led_reg        <= raw_vec ^ POL_MASK;
            if (cfg_re) begin
                cfg_rdata_reg <= rd_sel;
            end
        end
    end

    assign cfg_rdata  = cfg_rdata_reg;
    assign frame_tick = frame_tick_reg;
    assign led        = led_reg;

endmodule

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl: self-checking bench for led_ctrl (NUM_LEDS=3, PWM_BITS=4,
// PRESCALE=4, ACTIVE_LOW=1). Pin and frame_tick expectations come from
// closed-form timing of the described behaviour; readback expectations are
// queued when cfg_re is driven and compared when cfg_rdata is due.
module tb_led_ctrl;

    localparam int NL    = 3;
    localparam int PB    = 4;
    localparam int PRE   = 4;
    localparam int AL    = 1;
    localparam int STEPS = 1 << PB;
    localparam int FRAME = PRE * STEPS;
    localparam int DMAX  = STEPS - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic          cfg_re = 1'b0;
    logic [3:0]    cfg_addr = '0;
    logic [23:0]   cfg_wdata = '0;
    logic [23:0]   cfg_rdata;
    logic          frame_tick;
    logic [NL-1:0] led;

    led_ctrl #(
        .NUM_LEDS   (NL),
        .PWM_BITS   (PB),
        .PRESCALE   (PRE),
        .ACTIVE_LOW (AL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_re     (cfg_re),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .frame_tick (frame_tick),
        .led        (led)
    );

    always #5 clk = ~clk;

    // Number of clock edges since reset release.
    int n = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [23:0] got, input logic [23:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at n=%0d", tag, got, exp, n);
        end
    endtask

    // Bench view of each channel: config plus the edge 'a' where it took effect.
    typedef struct {
        logic [2:0] mode;
        logic [7:0] level;
        logic [7:0] period;
        int         a;
    } desc_t;

    desc_t cur [NL];
    desc_t prv [NL];

    typedef struct {
        int          due;
        logic [23:0] exp;
    } rd_exp_t;

    rd_exp_t sb [$];

    task automatic clear_model();
        for (int c = 0; c < NL; c++) begin
            cur[c] = '{3'd0, 8'd0, 8'd0, 0};
            prv[c] = cur[c];
        end
    endtask

    function automatic logic [23:0] pack_desc(input desc_t d);
        return {d.period, d.level, 5'b00000, d.mode};
    endfunction

    // Frame ticks a channel configured at edge a has consumed by edge m.
    function automatic int ticks(input int a, input int m);
        if (m - 1 < a) return 0;
        return (m - 1) / FRAME - (a - 1) / FRAME;
    endfunction

    function automatic logic exp_pin(input int c, input int k);
        desc_t d;
        int    m;
        int    t;
        int    s;
        int    duty;
        int    pwm;
        logic  raw;
        m   = k - 1;
        d   = (m >= cur[c].a) ? cur[c] : prv[c];
        pwm = (m / PRE) % STEPS;
        raw = 1'b0;
        if (m >= 0) begin
            case (d.mode)
                3'd1: raw = 1'b1;
                3'd2: raw = (pwm < int'(d.level[PB-1:0]));
                3'd3: begin
                    t   = ticks(d.a, m);
                    raw = ((t / (int'(d.period) + 1)) % 2) == 1;
                end
`ifdef LED_CTRL_BREATHE_EN
                3'd4: begin
                    t    = ticks(d.a, m);
                    s    = (t / (int'(d.period) + 1)) % (2 * DMAX);
                    duty = (s <= DMAX) ? s : 2 * DMAX - s;
                    raw  = (pwm < duty);
                end
`endif
                default: raw = 1'b0;
            endcase
        end
        return (AL != 0) ? !raw : raw;
    endfunction

    // Monitor: pins and frame_tick every cycle, readback when due.
    always @(negedge clk) begin
        logic [NL-1:0] exp_led;
        for (int c = 0; c < NL; c++) exp_led[c] = exp_pin(c, n);
        check_val("led", 24'(led), 24'(exp_led));
        check_val("frame_tick", 24'(frame_tick), 24'(n > 0 && (n % FRAME) == 0));
        if (sb.size() > 0) begin
            if (sb[0].due == n) begin
                check_val("rdata", cfg_rdata, sb[0].exp);
                void'(sb.pop_front());
            end else if (sb[0].due < n) begin
                check_val("rdata_missed", cfg_rdata, sb[0].exp);
                void'(sb.pop_front());
            end
        end
    end

    // One cfg transaction, started and ended on a falling edge.
    task automatic xact(input bit we, input bit re, input logic [3:0] addr,
                        input logic [2:0] mode, input logic [7:0] level, input logic [7:0] period);
        rd_exp_t e;
        if (re) begin
            e.due = n + 1;
            e.exp = (int'(addr) < NL) ? pack_desc(cur[addr]) : 24'h0;
            sb.push_back(e);
        end
        if (we && int'(addr) < NL) begin
            prv[addr] = cur[addr];
            cur[addr] = '{mode, level, period, n + 1};
        end
        cfg_we    = we;
        cfg_re    = re;
        cfg_addr  = addr;
        cfg_wdata = {period, level, 5'b00000, mode};
        $display("xact n=%0d we=%0b re=%0b addr=%0d mode=%0d level=%h period=%h",
                 n, we, re, addr, mode, level, period);
        @(negedge clk);
        cfg_we = 1'b0;
        cfg_re = 1'b0;
    endtask

    // Readback must still hold its last value without a new cfg_re.
    task automatic hold_check(input logic [23:0] exp);
        rd_exp_t e;
        e.due = n + 1;
        e.exp = exp;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        clear_model();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_led", 24'(led), 24'(3'b111));
        check_val("rst_rdata", cfg_rdata, 24'h0);
        check_val("rst_tick", 24'(frame_tick), 24'h0);
        rst = 1'b0;
        idle(140);

        xact(1'b0, 1'b1, 4'd2, 3'd0, 8'h00, 8'h00);   // read ch2 after reset
        xact(1'b0, 1'b1, 4'd5, 3'd0, 8'h00, 8'h00);   // read out of range

        xact(1'b1, 1'b0, 4'd1, 3'd2, 8'h04, 8'h00);   // ch1 PWM level 4
        idle(200);

        xact(1'b1, 1'b0, 4'd0, 3'd3, 8'h00, 8'h01);   // ch0 BLINK period 1
        idle(300);
        xact(1'b1, 1'b0, 4'd0, 3'd3, 8'h00, 8'h01);   // rewrite mid-period
        idle(400);

        xact(1'b1, 1'b0, 4'd2, 3'd1, 8'h00, 8'h00);   // ch2 ON
        xact(1'b0, 1'b1, 4'd2, 3'd0, 8'h00, 8'h00);   // read ch2
        idle(3);
        hold_check(24'h000001);
        xact(1'b0, 1'b1, 4'd5, 3'd0, 8'h00, 8'h00);   // read addr 5
        xact(1'b1, 1'b0, 4'd5, 3'd1, 8'hFF, 8'hFF);   // write addr 5: ignored
        idle(70);
        xact(1'b0, 1'b1, 4'd1, 3'd0, 8'h00, 8'h00);   // read ch1
        xact(1'b1, 1'b1, 4'd1, 3'd7, 8'hAB, 8'h12);   // same-cycle write+read
        xact(1'b0, 1'b1, 4'd1, 3'd0, 8'h00, 8'h00);   // post-write value
        idle(20);

        xact(1'b1, 1'b0, 4'd2, 3'd2, 8'h0F, 8'h00);   // ch2 PWM max level
        idle(130);

        xact(1'b1, 1'b0, 4'd0, 3'd4, 8'h00, 8'h00);   // ch0 BREATHE period 0
        idle(30 * FRAME + 150);

        xact(1'b1, 1'b0, 4'd0, 3'd1, 8'h00, 8'h00);
        xact(1'b1, 1'b0, 4'd1, 3'd1, 8'h00, 8'h00);
        xact(1'b1, 1'b0, 4'd2, 3'd1, 8'h00, 8'h00);
        idle(20);
        @(posedge clk);
        #3;
        rst = 1'b1;
        clear_model();
        #1;
        check_val("async_led", 24'(led), 24'(3'b111));
        check_val("async_tick", 24'(frame_tick), 24'h0);
        check_val("async_rdata", cfg_rdata, 24'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(140);
        xact(1'b0, 1'b1, 4'd0, 3'd0, 8'h00, 8'h00);   // ch0 back to OFF
        idle(3);

        if (sb.size() != 0) check_val("sb_leftover", 24'(sb.size()), 24'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
